// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fifo_entry_t;

  // Force a PC onto a word boundary; the low two bits are never meaningful.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Flushable circular FIFO holding fetched {pc, instr} pairs for the core.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fifo_entry_t   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fifo_entry_t   head,
  output logic          full
);

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full = (count == CW'(DEPTH));
  assign head = mem[rd_ptr];

  // Qualify push/pop so an empty pop or an overfull push can never corrupt state.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && (!full || do_pop);
  end

  // Pointer, count and storage update; flush wins over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues credit-limited memory requests,
// buffers in-order responses and drops stale ones after a redirect.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int          CW       = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            fifo_full;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;
  fifo_entry_t     push_entry;
  fifo_entry_t     head_entry;

  // Credit, handshake and push decisions; buffered plus in-flight never exceeds DEPTH.
  always_comb begin
    in_use     = {1'b0, fifo_count} + {1'b0, outstanding};
    credit_ok  = !fifo_full && (in_use < (CW + 1)'(DEPTH));
    req_valid  = !rst && !redirect && credit_ok;
    accept     = req_valid && req_ready;
    push       = rsp_valid && !redirect && (drop_cnt == '0);
    out_valid  = (fifo_count != '0);
    pop        = out_valid && out_ready;
    push_entry = '{pc: rsp_pc, instr: rsp_data};
  end

  assign req_addr  = fetch_pc;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

  // PC, outstanding-request and stale-drop bookkeeping; redirect restarts both PCs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp_valid);
      if (redirect) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
        drop_cnt <= outstanding - CW'(rsp_valid);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(PC_STEP);
        end
        if (rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .count    (fifo_count),
    .head     (head_entry),
    .full     (fifo_full)
  );

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end that sits directly upstream of the single-cycle RISC-V core. It owns the fetch PC and issues word reads to an instruction memory with a valid/ready request port and in-order, variable-latency responses. Returned instructions are buffered with their PCs in a small FIFO and handed to the core through a valid/ready output. On a core redirect (branch or jump) it flushes the FIFO, discards in-flight stale responses and restarts fetching at the new PC.

## Interface
- DEPTH, 4, FIFO entries; also the cap on entries plus outstanding requests (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request this cycle
- req_addr  out  32  fetch address (word aligned)
- rsp_valid  in  1  response valid; always accepted, no backpressure
- rsp_data  in  32  instruction word, in request order
- redirect  in  1  core requests fetch restart
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0
- out_valid  out  1  head entry valid
- out_ready  in  1  core consumes head entry
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction word

## Operation
- State: fetch_pc, rsp_pc (PC of next non-stale response), outstanding count, drop_cnt, FIFO count.
- req_addr = fetch_pc. req_valid = !rst && !redirect && (count + outstanding) < DEPTH.
- Request accept (req_valid && req_ready): fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response (rsp_valid): outstanding -= 1. If drop_cnt > 0: drop_cnt -= 1, data discarded. Else push {rsp_pc, rsp_data}, rsp_pc += 4. Overflow is impossible by the credit rule.
- Pop (out_valid && out_ready): head removed.
- Redirect: FIFO flushed (count = 0); fetch_pc and rsp_pc = {redirect_pc[31:2], 2'b00}; drop_cnt = outstanding − rsp_valid. Any rsp_valid in that cycle is discarded; no request is issued that cycle. A pop in the redirect cycle completes normally.
- Simultaneous accept, response and pop in one cycle update all counters consistently: the net change is applied to each counter.
- Every response arriving after a redirect is dropped until drop_cnt reaches 0.

## Timing
- Reset values: out_valid=0, req_valid=0, req_addr=RESET_PC, out_pc=0, out_instr=0. All counters are 0 and fetch_pc=rsp_pc=RESET_PC.
- The first cycle with rst low presents req_valid=1 and req_addr=RESET_PC.
- Response to output latency is 1 cycle. An entry pushed at edge N is visible with out_valid at cycle N+1; there is no combinational rsp-to-out bypass.
- Sustained throughput is 1 instruction per cycle when req_ready=1, the memory latency is below DEPTH, and out_ready=1.
- While req_ready=0, req_addr is held stable.
- out_pc and out_instr are stable while out_valid && !out_ready.
- Redirect takes effect at the clock edge. out_valid=0 in the next cycle. The first post-redirect request (req_addr=redirect_pc) is issued the cycle after redirect.
- rst asserted mid-operation overrides redirect and all traffic and forces the reset values at the next edge. Responses arriving after reset are not accounted for, so the memory must be reset together with this block.

## Structure
- Shared package fetch_pkg holds XLEN=32, PC_STEP=4, and the fifo entry struct {pc, instr}.
- Sub-module fetch_fifo: synchronous-reset, flushable circular FIFO, parameterised by DEPTH. It has push, pop and flush inputs and count, head and full outputs. Pointers wrap at DEPTH. Flush and push in the same cycle result in empty.
- The top level contains the counters, the credit logic and the drop logic.

## Test plan
- Streaming: reset, req_ready=1, memory with 1-cycle latency returning data=addr^32'hA5A5_0000, out_ready=1. Required: out_pc 0x0, 0x4, 0x8… on consecutive cycles with matching out_instr, and the first out_valid in cycle 3 after reset.
- Backpressure: out_ready=0. Required: exactly 4 accepted requests (0x0–0xC), then req_valid=0. A single pop allows exactly one new request, to 0x10.
- Request stall: req_ready=0 for 5 cycles. Required: req_addr stays at 0x0 with req_valid=1, and outstanding stays 0.
- Redirect with in-flight traffic: 3-cycle memory latency with 2 outstanding requests, then redirect_pc=0x103. Required: both stale responses are dropped, and the next out_pc is 0x100.
- Redirect, response and pop in the same cycle. Required: the popped entry is delivered, the response is dropped, drop_cnt equals the outstanding count minus 1, and out_valid is 0 in the next cycle.
- Reset mid-stream with 3 entries buffered. Required: out_valid=0 and req_addr=RESET_PC after the edge, and fetching restarts from RESET_PC.
